// File: rtl/painel_display_pkg.sv
// Shared constants for the debug 7-segment display: hex glyphs, blank codes, page codes.
package painel_display_pkg;

    localparam logic [7:0] ANODO_OFF = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    typedef enum logic [1:0] {
        PG_PC  = 2'd0,
        PG_PC4 = 2'd1,
        PG_RS  = 2'd2,
        PG_RT  = 2'd3
    } pagina_t;

    // Active-low gfedcba glyphs, entry 15 first so HEX_7SEG[n] selects digit n.
    localparam logic [15:0][6:0] HEX_7SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/painel_display_decodificador_7seg.sv
// Combinational nibble-to-segments decoder with a blank override.
module decodificador_7seg
    import painel_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segmentos
);

    assign segmentos = blank ? SEG_OFF : HEX_7SEG[nibble];

endmodule

// File: rtl/painel_display.sv
// Debug display: snapshots four core words and scans the selected one onto eight 7-segment digits.
module painel_display
    import painel_display_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_ZEROS = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        captura,
    input  logic [31:0] fonte0,
    input  logic [31:0] fonte1,
    input  logic [31:0] fonte2,
    input  logic [31:0] fonte3,
    input  logic        troca_pagina,
    output logic [7:0]  anodo,
    output logic [6:0]  segmentos,
    output logic [1:0]  pagina
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [31:0]      fonte_w [4];
    logic [31:0]      snap_reg [4];
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       idx_reg;
    logic             troca_prev_reg;
    pagina_t          pagina_reg;
    logic [7:0]       anodo_reg;
    logic [6:0]       segmentos_reg;

    logic [31:0] sel_word;
    logic [3:0]  nib [8];
    logic [7:0]  hi_zero;
    logic        blank;
    logic        div_terminal;
    logic        troca_edge;
    logic [6:0]  seg_dec;

    assign fonte_w = '{fonte0, fonte1, fonte2, fonte3};
    assign sel_word = snap_reg[pagina_reg];

    // hi_zero[i]: nibble i and every nibble above it are zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign nib[gi]     = sel_word[4*gi +: 4];
        assign hi_zero[gi] = ~|sel_word[31:4*gi];
    end

    assign blank        = (BLANK_ZEROS != 0) && (idx_reg != 3'd0) && hi_zero[idx_reg];
    assign div_terminal = (div_reg == DIV_LAST);
    assign troca_edge   = troca_pagina && !troca_prev_reg;

    decodificador_7seg u_dec (
        .nibble    (nib[idx_reg]),
        .blank     (blank),
        .segmentos (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) snap_reg[i] <= '0;
            div_reg        <= '0;
            idx_reg        <= '0;
            troca_prev_reg <= 1'b0;
            pagina_reg     <= PG_PC;
            anodo_reg      <= ANODO_OFF;
            segmentos_reg  <= SEG_OFF;
        end else begin
            if (captura) begin
                for (int i = 0; i < 4; i++) snap_reg[i] <= fonte_w[i];
            end

            troca_prev_reg <= troca_pagina;
            if (troca_edge) pagina_reg <= pagina_t'(pagina_reg + 2'd1);

            if (div_terminal) begin
                div_reg <= '0;
                idx_reg <= idx_reg + 3'd1;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end

            // The cycle the digit index moves, all anodes go dark so the old
            // glyph never flashes on the new digit.
            anodo_reg     <= div_terminal ? ANODO_OFF : ~(8'b1 << idx_reg);
            segmentos_reg <= seg_dec;
        end
    end

    assign anodo     = anodo_reg;
    assign segmentos = segmentos_reg;
    assign pagina    = pagina_reg;

endmodule

// File: tb/tb_painel_display.sv
// Bench for painel_display: directed scenarios plus random traffic against a cycle-count reference model.
module tb_painel_display;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        captura = 1'b0;
    logic        troca = 1'b0;
    logic [31:0] fontes [4] = '{default: 32'h0};

    logic [7:0] anodo0, anodo1;
    logic [6:0] seg0, seg1;
    logic [1:0] pag0, pag1;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_snap [4];
    int          m_page;
    int          m_t;
    bit          m_prev;
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    painel_display #(.CLK_DIV(CLK_DIV), .BLANK_ZEROS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .captura(captura),
        .fonte0(fontes[0]), .fonte1(fontes[1]), .fonte2(fontes[2]), .fonte3(fontes[3]),
        .troca_pagina(troca), .anodo(anodo0), .segmentos(seg0), .pagina(pag0)
    );

    painel_display #(.CLK_DIV(CLK_DIV), .BLANK_ZEROS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .captura(captura),
        .fonte0(fontes[0]), .fonte1(fontes[1]), .fonte2(fontes[2]), .fonte3(fontes[3]),
        .troca_pagina(troca), .anodo(anodo1), .segmentos(seg1), .pagina(pag1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: predict the registered outputs from the model state seen at
    // this edge, then advance the model with the inputs sampled at the edge.
    task automatic cycle();
        int          idx;
        logic [31:0] w;
        logic [3:0]  nib;
        logic [7:0]  exp_an;
        logic [6:0]  exp_s0, exp_s1;
        bit          check_seg;
        @(posedge clk);
        check_seg = 1'b1;
        if (!reset_n) begin
            m_t = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 32'h0;
            m_page = 0;
            m_prev = 1'b0;
            exp_an = 8'hFF;
            exp_s0 = 7'h7F;
            exp_s1 = 7'h7F;
        end else begin
            idx = (m_t / CLK_DIV) % 8;
            w   = m_snap[m_page];
            nib = 4'((w >> (4 * idx)) & 32'hF);
            if ((m_t % CLK_DIV) == CLK_DIV - 1) begin
                exp_an    = 8'hFF;
                check_seg = 1'b0;
            end else begin
                exp_an = 8'hFF ^ (8'd1 << idx);
            end
            exp_s0 = hex_tab[nib];
            exp_s1 = (idx != 0 && (w >> (4 * idx)) == 32'h0) ? 7'h7F : hex_tab[nib];
            m_t++;
            if (captura) for (int i = 0; i < 4; i++) m_snap[i] = fontes[i];
            if (troca && !m_prev) m_page = (m_page + 1) % 4;
            m_prev = troca;
        end
        #1;
        chk("anodo", {24'h0, anodo0}, {24'h0, exp_an});
        chk("anodo_blank", {24'h0, anodo1}, {24'h0, exp_an});
        chk("pagina", {30'h0, pag0}, 32'(m_page));
        chk("pagina_blank", {30'h0, pag1}, 32'(m_page));
        if (check_seg) begin
            chk("segmentos", {25'h0, seg0}, {25'h0, exp_s0});
            chk("segmentos_blank", {25'h0, seg1}, {25'h0, exp_s1});
        end
        $display("t=%0t rst_n=%0b cap=%0b troca=%0b anodo=%h seg=%h/%h pagina=%0d",
                 $time, reset_n, captura, troca, anodo0, seg0, seg1, pag0);
    endtask

    task automatic page_edge(input int hold);
        troca = 1'b1;
        repeat (hold) cycle();
        troca = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        // Reset held for three cycles, then first digit shows 0 on digit 0.
        reset_n = 1'b0;
        repeat (3) cycle();
        chk("rst_anodo", {24'h0, anodo0}, 32'h0000_00FF);
        reset_n = 1'b1;
        cycle();
        chk("rel_anodo", {24'h0, anodo0}, 32'h0000_00FE);
        chk("rel_seg", {25'h0, seg0}, 32'h0000_0040);

        // Capture plus full scan with wrap.
        fontes[0] = 32'h0040_00A8;
        captura = 1'b1;
        cycle();
        captura = 1'b0;
        fontes[0] = 32'h0;
        repeat (40) cycle();

        // Page cycling, page 3 shows 0x1F, third edge held for 10 cycles.
        fontes[3] = 32'd31;
        captura = 1'b1;
        cycle();
        captura = 1'b0;
        for (int k = 0; k < 5; k++) begin
            page_edge(k == 2 ? 10 : 2);
            if (k == 2) repeat (34) cycle();
        end
        chk("page_after5", {30'h0, pag0}, 32'd1);

        // Capture hold on page 1 while the source keeps changing.
        fontes[1] = 32'h0000_0004;
        captura = 1'b1;
        cycle();
        captura = 1'b0;
        repeat (36) begin
            fontes[1] = $urandom;
            cycle();
        end

        // Zero value: digit 0 still shows 0 with blanking enabled.
        fontes[1] = 32'h0;
        captura = 1'b1;
        cycle();
        captura = 1'b0;
        repeat (34) cycle();

        // Back to page 0, then capture and page edge in the same cycle.
        for (int k = 0; k < 3; k++) page_edge(1);
        fontes[1] = 32'hFFFF_FFFF;
        captura = 1'b1;
        troca = 1'b1;
        cycle();
        captura = 1'b0;
        troca = 1'b0;
        chk("simul_page", {30'h0, pag0}, 32'd1);
        repeat (36) cycle();

        // Random traffic.
        repeat (600) begin
            for (int i = 0; i < 4; i++)
                fontes[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            captura = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) troca = ~troca;
            cycle();
        end

        // Reset mid-scan.
        captura = 1'b0;
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        chk("midrst_anodo", {24'h0, anodo0}, 32'h0000_00FE);
        chk("midrst_seg", {25'h0, seg0}, 32'h0000_0040);
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/painel_display.md
Name: painel_display

Overview:
- Debug display stage downstream of the single-cycle MIPS core.
- Snapshots four 32-bit core observation words: PC, PC+4, rs index and rt index.
- Shows one selected word as 8 hex digits on a time-multiplexed 7-segment display.
- Owns its refresh divider, page selection and scan sequencing; the core only drives the data words and a capture strobe.

Parameters:
- CLK_DIV, 50000: clk cycles each digit stays lit; legal range 2..2^20.
- BLANK_ZEROS, 0: 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- captura  in  1  single-cycle strobe; latch fonte0..fonte3.
- fonte0  in  32  page 0 source, PC.
- fonte1  in  32  page 1 source, PC+4.
- fonte2  in  32  page 2 source, rs index zero-extended.
- fonte3  in  32  page 3 source, rt index zero-extended.
- troca_pagina  in  1  level input, already debounced; each rising edge advances the page.
- anodo  out  8  digit enables, active-low; bit i = digit i; digit 0 = least-significant nibble.
- segmentos  out  7  segments, active-low; bit0=a … bit6=g.
- pagina  out  2  currently displayed page.

Behaviour:
- Reset (reset_n=0 at a clk edge), synchronous, overrides everything:
  - anodo=8'hFF, segmentos=7'h7F, pagina=0.
  - snapshots=0, divider=0, digit index=0, troca_pagina edge register=0.
- Capture: captura=1 loads all four snapshot registers in the same edge. Snapshots are otherwise held, so the display is stable while the core runs.
- Page: rising edge detected as troca_pagina=1 while the previous-sample register is 0. On an edge, pagina increments and wraps from 3 to 0. A held-high level advances exactly once.
- Divider: counts 0..CLK_DIV-1. At terminal count it returns to 0 and the digit index advances, wrapping from 7 to 0. The divider never pauses for captura or a page change.
- Output pipeline, 1 cycle: anodo and segmentos are registered from the current index, page and snapshot.
  - anodo = all ones except bit[index] = 0.
  - segmentos = encoding of nibble[index] of the selected snapshot.
- Anti-ghosting: on the cycle the index changes, anodo is forced to 8'hFF for exactly that one output cycle; the new digit appears on the following cycle.
- Blanking, BLANK_ZEROS=1: a digit with all of itself and its higher nibbles zero drives segmentos=7'h7F. anodo is still low for that digit.
- Hex encoding, active-low gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Simultaneous captura and page edge: both take effect in that edge. The next output cycle shows the new page of the new snapshot.
- Reset mid-scan: the next output after reset release is digit 0 of page 0, value 0, after 1 cycle.

Decomposition:
- Shared include file:
  - 16-entry hex-to-7-segment constant table.
  - Anode-all-off (8'hFF) and segments-off (7'h7F) constants.
  - Page codes PG_PC=0, PG_PC4=1, PG_RS=2, PG_RT=3.
- Sub-module decodificador_7seg: purely combinational, 4-bit nibble plus blank flag in, 7-bit active-low segments out. Reused by future display blocks.

Test Plan:
- Reset, CLK_DIV=4: hold reset_n=0 for 3 cycles, then release → anodo=FF and segmentos=7F during reset. One cycle after release, anodo=FE and segmentos=40 (digit 0, value 0).
- Capture plus scan, CLK_DIV=4: fonte0=32'h0040_00A8 with captura pulsed → digit 0 shows 00 (8), digit 1 shows 08 (A), digit 2 shows 40 (0). anodo steps FE→FF→FD→FF→FB, each digit held 3 cycles after a 1-cycle blank. The index wraps from 7 back to FE.
- Page cycling: 5 rising edges of troca_pagina, with one edge held high for 10 cycles → pagina goes 1,2,3,0,1. The held level counts once. Page 3 with fonte3=5'd31 captured shows digits 0x1F.
- Capture hold: captura pulsed with fonte0=32'h0000_0004, then fonte0 changes every cycle without captura → displayed digits stay 4 and 0s.
- Blanking, BLANK_ZEROS=1, snapshot 32'h0000_0004 → digit 0 shows segmentos=19. Digits 1..7 show 7F while their anodo bit is low. A value of 0 shows 40 on digit 0.
- Simultaneous events: captura with fonte1=32'hFFFF_FFFF in the same cycle as a page edge from 0 → pagina=1. All digits show 0E.
